// File: rtl/fde_pipe_regs.sv
`default_nettype none
// ============================================================================
// Module   : fde_pipe_regs
// Brief    : PC, IF/ID and ID/EX pipeline registers for the 5-stage MIPS core.
//            Optional performance counters enabled by macro PIPE_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fde_pipe_regs #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushE,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
    input  logic [31:0] InstrF,
    input  logic [7:0]  CtrlD,
    input  logic [31:0] RD1D,
    input  logic [31:0] RD2D,
    input  logic [31:0] SignImmD,
    input  logic [4:0]  RsD,
    input  logic [4:0]  RtD,
    input  logic [4:0]  RdD,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic        ValidE,
    output logic [7:0]  CtrlE,
    output logic [31:0] RD1E,
    output logic [31:0] RD2E,
    output logic [31:0] SignImmE,
    output logic [4:0]  RsE,
    output logic [4:0]  RtE,
    output logic [4:0]  RdE,
    output logic        RegWriteE,
    output logic        MemtoRegE,
    output logic [31:0] StallCnt,
    output logic [31:0] BubbleCnt
);

    logic [31:0] r_pcF;
    logic [31:0] r_instrD;
    logic [31:0] r_pcPlus4D;
    logic        r_validD;
    logic        r_validE;
    logic [7:0]  r_ctrlE;
    logic [31:0] r_rd1E;
    logic [31:0] r_rd2E;
    logic [31:0] r_signImmE;
    logic [4:0]  r_rsE;
    logic [4:0]  r_rtE;
    logic [4:0]  r_rdE;
    logic [31:0] w_pcPlus4F;

    // Wraps modulo 2^32 naturally.
    assign w_pcPlus4F = r_pcF + 32'd4;

    // A stalled PC ignores a redirect; the hazard unit re-presents it later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcF <= RESET_PC;
        end else if (!StallF) begin
            r_pcF <= PCSrcD ? PCBranchD : w_pcPlus4F;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instrD   <= 32'd0;
            r_pcPlus4D <= 32'd0;
            r_validD   <= 1'b0;
        end else if (StallD) begin
            r_instrD   <= r_instrD;
            r_pcPlus4D <= r_pcPlus4D;
            r_validD   <= r_validD;
        end else if (PCSrcD) begin
            r_instrD   <= 32'd0;
            r_pcPlus4D <= 32'd0;
            r_validD   <= 1'b0;
        end else begin
            r_instrD   <= InstrF;
            r_pcPlus4D <= w_pcPlus4F;
            r_validD   <= 1'b1;
        end
    end

    // E never holds: a flush zeroes every field, producing an inert bubble.
    always_ff @(posedge clk) begin
        if (rst || FlushE) begin
            r_validE   <= 1'b0;
            r_ctrlE    <= 8'd0;
            r_rd1E     <= 32'd0;
            r_rd2E     <= 32'd0;
            r_signImmE <= 32'd0;
            r_rsE      <= 5'd0;
            r_rtE      <= 5'd0;
            r_rdE      <= 5'd0;
        end else begin
            r_validE   <= r_validD;
            r_ctrlE    <= CtrlD;
            r_rd1E     <= RD1D;
            r_rd2E     <= RD2D;
            r_signImmE <= SignImmD;
            r_rsE      <= RsD;
            r_rtE      <= RtD;
            r_rdE      <= RdD;
        end
    end

`ifdef PIPE_PERF_EN
    logic [31:0] r_stallCnt;
    logic [31:0] r_bubbleCnt;
    logic        w_bubble;

    assign w_bubble = FlushE | (PCSrcD & ~StallD);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stallCnt  <= 32'd0;
            r_bubbleCnt <= 32'd0;
        end else begin
            if (StallF) begin
                r_stallCnt <= r_stallCnt + 32'd1;
            end
            if (w_bubble) begin
                r_bubbleCnt <= r_bubbleCnt + 32'd1;
            end
        end
    end

    assign StallCnt  = r_stallCnt;
    assign BubbleCnt = r_bubbleCnt;
`else
    assign StallCnt  = 32'd0;
    assign BubbleCnt = 32'd0;
`endif

    assign PCF       = r_pcF;
    assign PCPlus4F  = w_pcPlus4F;
    assign InstrD    = r_instrD;
    assign PCPlus4D  = r_pcPlus4D;
    assign ValidD    = r_validD;
    assign ValidE    = r_validE;
    assign CtrlE     = r_ctrlE;
    assign RD1E      = r_rd1E;
    assign RD2E      = r_rd2E;
    assign SignImmE  = r_signImmE;
    assign RsE       = r_rsE;
    assign RtE       = r_rtE;
    assign RdE       = r_rdE;
    assign RegWriteE = r_ctrlE[7];
    assign MemtoRegE = r_ctrlE[6];

endmodule
`default_nettype wire
